// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// fetch_sequencer_if : fetch-stage handshake bundle (imem, hazard, EX, IF/ID)
// Revision 1.0
// ============================================================================
interface fetch_sequencer_if #(
  parameter int PC_W = 32
);
  logic            imem_req;
  logic            imem_ack;
  logic            stall;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            halt;
  logic            resume;
  logic [PC_W-1:0] pc;
  logic            fetch_valid;
  logic [PC_W-1:0] fetch_pc;
  logic            flush;
  logic            halted;
  logic [31:0]     fetch_count;
  logic [31:0]     stall_count;

  // The sequencer side drives the fetch address, IF/ID controls and counters.
  modport master (
    output imem_req, pc, fetch_valid, fetch_pc, flush, halted,
           fetch_count, stall_count,
    input  imem_ack, stall, redirect, redirect_pc, halt, resume
  );

  modport slave (
    input  imem_req, pc, fetch_valid, fetch_pc, flush, halted,
           fetch_count, stall_count,
    output imem_ack, stall, redirect, redirect_pc, halt, resume
  );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// fetch_sequencer : PC sequencing, imem fetch handshake, redirect flush, halt
// Revision 1.0
// ============================================================================
module fetch_sequencer #(
  parameter int              PC_W         = 32,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 2
) (
  input  wire logic         clk,
  input  wire logic         reset,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Counter holds remaining flush cycles minus one, so 0 means "last one".
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic            imem_req_q, imem_req_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            flush_q, flush_d;
  logic            halted_q, halted_d;
  logic [31:0]     fetch_count_q, fetch_count_d;
  logic [31:0]     stall_count_q, stall_count_d;
  logic [3:0]      flush_cnt_q, flush_cnt_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_pc_d    = fetch_pc_q;
    imem_req_d    = imem_req_q;
    fetch_valid_d = 1'b0;
    flush_d       = flush_q;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    flush_cnt_d   = flush_cnt_q;

    case (state_q)
      ST_BOOT: begin
        state_d    = ST_FETCH;
        imem_req_d = 1'b1;
      end

      ST_FETCH: begin
        if (bus.redirect) begin
          // Any concurrent ack is dropped: the fetched word is on the wrong path.
          state_d     = ST_FLUSH;
          pc_d        = bus.redirect_pc;
          imem_req_d  = 1'b0;
          flush_d     = 1'b1;
          flush_cnt_d = FLUSH_LOAD;
        end else if (bus.halt) begin
          state_d    = ST_HALT;
          imem_req_d = 1'b0;
          halted_d   = 1'b1;
        end else if (imem_req_q && bus.imem_ack) begin
          if (bus.stall) begin
            stall_count_d = stall_count_q + 32'd1;
          end else begin
            fetch_valid_d = 1'b1;
            fetch_pc_d    = pc_q;
            pc_d          = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
            fetch_count_d = fetch_count_q + 32'd1;
          end
        end
      end

      ST_FLUSH: begin
        if (bus.redirect) begin
          pc_d        = bus.redirect_pc;
          flush_cnt_d = FLUSH_LOAD;
        end else if (flush_cnt_q == 4'd0) begin
          state_d    = ST_FETCH;
          imem_req_d = 1'b1;
          flush_d    = 1'b0;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end

      ST_HALT: begin
        // Redirect wins over resume so a pending branch is never lost.
        if (bus.redirect) begin
          state_d     = ST_FLUSH;
          pc_d        = bus.redirect_pc;
          halted_d    = 1'b0;
          flush_d     = 1'b1;
          flush_cnt_d = FLUSH_LOAD;
        end else if (bus.resume) begin
          state_d    = ST_FETCH;
          halted_d   = 1'b0;
          imem_req_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      fetch_pc_q    <= '0;
      imem_req_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= 32'd0;
      stall_count_q <= 32'd0;
      flush_cnt_q   <= 4'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      imem_req_q    <= imem_req_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.pc          = pc_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_pc    = fetch_pc_q;
  assign bus.flush       = flush_q;
  assign bus.halted      = halted_q;
  assign bus.fetch_count = fetch_count_q;
  assign bus.stall_count = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fetch_sequencer : scoreboard bench with a behavioural fetch-stage model
// Revision 1.0
// ============================================================================
module tb_fetch_sequencer;

  localparam int          PC_W         = 32;
  localparam int          FLUSH_CYCLES = 2;
  localparam logic [31:0] RESET_PC     = 32'd0;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.PC_W(PC_W)) bus();

  fetch_sequencer #(
    .PC_W        (PC_W),
    .RESET_PC    (RESET_PC),
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model of what the outputs should show in the current cycle.
  bit          e_known = 1'b0;
  bit          e_boot;
  bit          e_req;
  bit          e_halted;
  bit          e_valid;
  int          flush_left;
  logic [31:0] e_pc, e_fetch_pc, e_fcount, e_scount;
  logic [31:0] exp_q[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk1(string name, logic act, logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endfunction

  function automatic void check_outputs();
    if (e_known) begin
      chk ("pc",          bus.pc,          e_pc);
      chk1("imem_req",    bus.imem_req,    e_req);
      chk1("flush",       bus.flush,       flush_left > 0);
      chk1("halted",      bus.halted,      e_halted);
      chk1("fetch_valid", bus.fetch_valid, e_valid);
      chk ("fetch_pc_reg", bus.fetch_pc,   e_fetch_pc);
      chk ("fetch_count", bus.fetch_count, e_fcount);
      chk ("stall_count", bus.stall_count, e_scount);
    end
  endfunction

  // Advances the model by one clock given the inputs presented this cycle.
  function automatic void model(bit rs, bit ack, bit st, bit rd, logic [31:0] rpc,
                                bit hl, bit rsm);
    e_valid = 1'b0;
    if (rs) begin
      e_known = 1'b1; e_boot = 1'b1; e_req = 1'b0; e_halted = 1'b0;
      flush_left = 0; e_pc = RESET_PC; e_fetch_pc = 32'd0;
      e_fcount = 32'd0; e_scount = 32'd0;
    end else if (!e_known) begin
      e_known = 1'b0;
    end else if (e_boot) begin
      e_boot = 1'b0; e_req = 1'b1;
    end else if (e_halted) begin
      if (rd) begin
        e_pc = rpc; e_halted = 1'b0; flush_left = FLUSH_CYCLES;
      end else if (rsm) begin
        e_halted = 1'b0; e_req = 1'b1;
      end
    end else if (flush_left > 0) begin
      if (rd) begin
        e_pc = rpc; flush_left = FLUSH_CYCLES;
      end else begin
        flush_left--;
        if (flush_left == 0) e_req = 1'b1;
      end
    end else begin
      if (rd) begin
        e_pc = rpc; e_req = 1'b0; flush_left = FLUSH_CYCLES;
      end else if (hl) begin
        e_req = 1'b0; e_halted = 1'b1;
      end else if (ack && st) begin
        e_scount++;
      end else if (ack) begin
        exp_q.push_back(e_pc);
        e_valid = 1'b1; e_fetch_pc = e_pc; e_pc++; e_fcount++;
      end
    end
  endfunction

  task automatic step(input bit rs, input bit ack, input bit st, input bit rd,
                      input logic [31:0] rpc, input bit hl, input bit rsm);
    @(negedge clk);
    check_outputs();
    reset           = rs;
    bus.imem_ack    = ack;
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.halt        = hl;
    bus.resume      = rsm;
    model(rs, ack, st, rd, rpc, hl, rsm);
  endtask

  task automatic run(input bit ack, input bit st);
    step(1'b0, ack, st, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic jump(input logic [31:0] target);
    step(1'b0, 1'b1, 1'b0, 1'b1, target, 1'b0, 1'b0);
  endtask

  // Monitor: every presented transfer must match the oldest expected fetch.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.fetch_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_transfer: got fetch_pc 0x%08h, expected no transfer at %0t",
                   bus.fetch_pc, $time);
        end else begin
          chk("scoreboard_fetch_pc", bus.fetch_pc, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bus.imem_ack = 1'b0; bus.stall = 1'b0; bus.redirect = 1'b0;
    bus.redirect_pc = 32'd0; bus.halt = 1'b0; bus.resume = 1'b0;

    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

    // Sequential fetch from reset.
    repeat (5) run(1'b1, 1'b0);
    run(1'b0, 1'b0);
    chk("t1_fetch_count", bus.fetch_count, 32'd4);
    chk("t1_last_fetch_pc", bus.fetch_pc, 32'd3);

    // Stall while ack is high at pc 5.
    run(1'b1, 1'b0);
    repeat (3) begin
      run(1'b1, 1'b1);
    end
    chk("t2_pc_held", bus.pc, 32'd5);
    chk1("t2_no_valid", bus.fetch_valid, 1'b0);
    run(1'b1, 1'b0);
    run(1'b0, 1'b0);
    chk("t2_stall_count", bus.stall_count, 32'd3);
    chk("t2_fetch_pc", bus.fetch_pc, 32'd5);

    // Redirect with a concurrent ack at pc 7.
    run(1'b1, 1'b0);
    chk("t3_pc_before", bus.pc, 32'd6);
    jump(32'h40);
    run(1'b1, 1'b0);
    chk1("t3_flush_1", bus.flush, 1'b1);
    chk1("t3_no_valid_7", bus.fetch_valid, 1'b0);
    chk("t3_pc_target", bus.pc, 32'h40);
    run(1'b1, 1'b0);
    chk1("t3_flush_2", bus.flush, 1'b1);
    run(1'b1, 1'b0);
    chk1("t3_flush_done", bus.flush, 1'b0);
    chk1("t3_req_back", bus.imem_req, 1'b1);
    run(1'b0, 1'b0);
    chk("t3_fetch_pc", bus.fetch_pc, 32'h40);

    // Halt at pc 9, hold, then resume.
    jump(32'd9);
    run(1'b0, 1'b0);
    run(1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      run(1'b1, 1'b0);
      chk1("t4_halted", bus.halted, 1'b1);
      chk1("t4_req_low", bus.imem_req, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    run(1'b1, 1'b0);
    chk1("t4_resumed", bus.halted, 1'b0);
    run(1'b0, 1'b0);
    chk("t4_fetch_pc", bus.fetch_pc, 32'd9);

    // PC wrap at all-ones.
    jump(32'hFFFF_FFFF);
    run(1'b0, 1'b0);
    run(1'b0, 1'b0);
    run(1'b1, 1'b0);
    run(1'b0, 1'b0);
    chk("t5_fetch_pc", bus.fetch_pc, 32'hFFFF_FFFF);
    chk("t5_pc_wrapped", bus.pc, 32'd0);

    // Reset in the middle of a flush.
    jump(32'h123);
    run(1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    run(1'b1, 1'b0);
    chk("t6a_pc", bus.pc, RESET_PC);
    chk1("t6a_flush", bus.flush, 1'b0);
    chk("t6a_fetch_count", bus.fetch_count, 32'd0);
    repeat (3) run(1'b1, 1'b0);

    // Reset while halted.
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    run(1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    run(1'b1, 1'b0);
    chk1("t6b_halted", bus.halted, 1'b0);
    chk("t6b_pc", bus.pc, RESET_PC);
    chk1("t6b_req", bus.imem_req, 1'b0);
    repeat (3) run(1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFE + 32'($urandom_range(0, 1)))
                                        : $urandom;
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 19) == 0,
           tgt,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 4) == 0);
    end

    repeat (3) run(1'b0, 1'b0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
